// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and constants for the OBI data responder.
package cv32e40p_obi_resp_pkg;

    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef struct packed {
        logic                  valid;
        logic [OBI_DATA_W-1:0] rdata;
    } resp_stage_t;

endpackage

// File: rtl/cv32e40p_obi_resp_sram.sv
// Single-port word array with byte-lane write enables and a registered read port.
module cv32e40p_obi_resp_sram
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [OBI_BE_W-1:0]   be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [OBI_DATA_W-1:0] wdata_i,
    output logic [OBI_DATA_W-1:0] rdata_o
);
    logic [OBI_DATA_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [OBI_DATA_W-1:0] rdata_q;

    // Read data only moves on reads, so it holds across writes and idle cycles.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < int'(OBI_BE_W); i++) begin
                    if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-side responder: scratchpad with fixed read latency and an outstanding limit.
// Define CV32E40P_OBI_RESP_STALL_EN to inject pseudo-random grant stalls from an LFSR.
module cv32e40p_obi_data_responder
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [OBI_BE_W-1:0]   data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [OBI_DATA_W-1:0] data_wdata_i,
    output logic [OBI_DATA_W-1:0] data_rdata_o
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hs, stall;
    logic                  s0_valid_q, s0_valid_d;
    logic                  s0_zero_q, s0_zero_d;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [OBI_DATA_W-1:0] sram_rdata;
    resp_stage_t           stage0, last;
    logic                  unused_addr;

    assign word_addr   = data_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0] & lfsr_q[1];
`else
    assign stall = 1'b0;
`endif

    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign data_gnt_o = data_req_i && !stall &&
                        ((cnt_q < CNT_W'(MAX_OUTSTANDING)) || data_rvalid_o);
    assign hs         = data_gnt_o;

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !data_rvalid_o)      cnt_d = cnt_q + 1'b1;
        else if (!hs && data_rvalid_o) cnt_d = cnt_q - 1'b1;
        s0_valid_d = hs;
        s0_zero_d  = hs ? data_we_i : s0_zero_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_zero_q  <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            s0_valid_q <= s0_valid_d;
            s0_zero_q  <= s0_zero_d;
        end
    end

    cv32e40p_obi_resp_sram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (hs),
        .we_i    (data_we_i),
        .be_i    (data_be_i),
        .addr_i  (word_addr),
        .wdata_i (data_wdata_i),
        .rdata_o (sram_rdata)
    );

    // Stage 0 data is the SRAM read register, masked to zero for writes and after reset.
    assign stage0 = '{valid: s0_valid_q, rdata: (s0_zero_q ? '0 : sram_rdata)};

    if (RD_LATENCY == 1) begin : g_no_tail
        assign last = stage0;
    end else begin : g_tail
        resp_stage_t tail_q [RD_LATENCY-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(RD_LATENCY) - 1; i++) tail_q[i] <= '0;
            end else begin
                tail_q[0] <= stage0;
                for (int i = 1; i < int'(RD_LATENCY) - 1; i++) tail_q[i] <= tail_q[i-1];
            end
        end

        assign last = tail_q[RD_LATENCY-2];
    end

    assign data_rvalid_o = last.valid;
    assign data_rdata_o  = last.rdata;

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Self-checking bench: directed vector table, throttle/reset sequences, random traffic vs model.
module tb_cv32e40p_obi_data_responder;
    localparam int unsigned AW   = 12;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, gnt, rvalid;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_data_responder #(
        .ADDR_WIDTH      (AW),
        .RD_LATENCY      (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_req_i    (req),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .data_rdata_o  (rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] mem_m [int unsigned];
    logic [31:0] last_rdata = '0;
    logic [31:0] cur;
    int unsigned cyc = 0;
    int unsigned widx;
    int unsigned n_rvalid = 0, n_hs = 0, n_drop = 0, n_stall = 0;
    logic        exp_rv, base_gnt;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_drop += pend_q.size();
            pend_q.delete();
            last_rdata = '0;
            check("rvalid_in_reset", 32'(rvalid), 32'h0);
            check("rdata_in_reset", rdata, 32'h0);
        end else begin
            exp_rv   = (pend_q.size() != 0) && (pend_q[0].due == cyc);
            base_gnt = req && ((pend_q.size() < MAXO) || exp_rv);
`ifdef CV32E40P_OBI_RESP_STALL_EN
            check("gnt_within_rule", 32'(gnt & ~base_gnt), 32'h0);
            if (base_gnt && !gnt) n_stall++;
`else
            check("gnt", 32'(gnt), 32'(base_gnt));
`endif
            check("rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv) begin
                check("rdata", rdata, pend_q[0].data);
                last_rdata = pend_q[0].data;
                n_rvalid++;
                void'(pend_q.pop_front());
            end else begin
                check("rdata_hold", rdata, last_rdata);
            end
            if (req && gnt) begin
                n_hs++;
                widx = 32'(addr[AW+1:2]);
                if (we) begin
                    cur = mem_m.exists(widx) ? mem_m[widx] : 32'h0;
                    for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
                    mem_m[widx] = cur;
                    pend_q.push_back('{due: cyc + LAT, data: 32'h0});
                end else begin
                    pend_q.push_back('{due: cyc + LAT, data: mem_m[widx]});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; holds the request until granted.
    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, output int unsigned hs_cyc,
                         output int unsigned waited);
        waited = 0;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        forever begin
            @(negedge clk);
            if (gnt) break;
            waited++;
            if (waited > 50) begin
                n_tests++; n_fail++;
                $display("FAIL grant_timeout: got no grant, expected one within 50 cycles");
                break;
            end
        end
        hs_cyc = cyc;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_resp(input int unsigned hs_cyc, output logic [31:0] d,
                             output int unsigned lat);
        int unsigned n = 0;
        forever begin
            @(negedge clk);
            if (rvalid) break;
            n++;
            if (n > 50) begin
                n_tests++; n_fail++;
                $display("FAIL resp_timeout: got no rvalid, expected one within 50 cycles");
                break;
            end
        end
        d   = rdata;
        lat = cyc - hs_cyc;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [12];
    int unsigned hs1, hs2, wt, lat, ng, k, rv0;
    logic [31:0] got;
    logic [5:0]  gpat;

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        "wr_full"};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEADBEEF, "rd_after_wr"};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0,        "prefill_20"};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0,        "wr_be0101"};
        vecs[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h11BB33DD, "rd_be_merge"};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h5A5A5A5A, 32'h0,        "wr_alias_base"};
        vecs[6]  = '{1'b0, 4'hF, 32'h0000_4004, 32'h0,        32'h5A5A5A5A, "rd_alias"};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h01234567, 32'h0,        "prefill_08"};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0008, 32'hFFFFFFFF, 32'h0,        "wr_be0000"};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0008, 32'h0,        32'h01234567, "rd_be0000"};
        vecs[10] = '{1'b0, 4'hF, 32'h0000_0103, 32'h0,        32'hDEADBEEF, "rd_low_bits"};
        vecs[11] = '{1'b0, 4'hF, 32'hFFFF_C100, 32'h0,        32'hDEADBEEF, "rd_upper_alias"};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_gnt_idle", 32'(gnt), 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        req = 1'b1;
        #1;
        check("reset_gnt_on_req", 32'(gnt), 32'h1);
        req = 1'b0;
        @(posedge clk); #1;

        // Directed table, one transaction at a time.
        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, hs1, wt);
            wait_resp(hs1, got, lat);
            check(vecs[i].name, got, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, LAT);
`ifndef CV32E40P_OBI_RESP_STALL_EN
            check({vecs[i].name, "_gnt_wait"}, wt, 32'h0);
`endif
        end

        // Back-to-back write then read of the same word; the model checks the data.
        issue(1'b1, 4'hF, 32'h30, 32'h12345678, hs1, wt);
        issue(1'b0, 4'hF, 32'h30, 32'h0, hs2, wt);
`ifndef CV32E40P_OBI_RESP_STALL_EN
        check("b2b_gnt_spacing", hs2 - hs1, 32'h1);
`endif
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Throttle: request held for 6 reads.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h100;
        ng = 0; k = 0; gpat = '0; rv0 = n_rvalid;
        while (ng < 6 && k < 60) begin
            @(negedge clk);
            if (k < 6) gpat[k] = gnt;
            if (gnt) ng++;
            k++;
            @(posedge clk); #1;
        end
        req = 1'b0;
`ifndef CV32E40P_OBI_RESP_STALL_EN
        check("throttle_gnt_pattern", 32'(gpat), 32'b011011);
`endif
        check("throttle_grants", ng, 32'd6);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("throttle_rvalids", n_rvalid - rv0, 32'd6);

        // Reset with two reads in flight.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h20;
        ng = 0; k = 0;
        while (ng < 2 && k < 60) begin
            @(negedge clk);
            if (gnt) ng++;
            k++;
            @(posedge clk); #1;
        end
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv0 = n_rvalid;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("no_rvalid_after_rst", n_rvalid - rv0, 32'h0);
        issue(1'b0, 4'hF, 32'h20, 32'h0, hs1, wt);
        wait_resp(hs1, got, lat);
        check("mem_kept_after_rst", got, 32'h11BB33DD);
`ifndef CV32E40P_OBI_RESP_STALL_EN
        check("cnt_zero_after_rst", wt, 32'h0);
`endif

        // Random traffic over a prefilled 16-word window with random alias bits.
        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom, hs1, wt);
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
            issue(1'($urandom_range(1)), 4'($urandom_range(15)),
                  ($urandom & 32'hFFFF_C000) | (32'h200 + 32'($urandom_range(15) * 4))
                      | 32'($urandom_range(3)),
                  $urandom, hs1, wt);
        end
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("resp_count", n_rvalid + n_drop, n_hs);
`ifdef CV32E40P_OBI_RESP_STALL_EN
        check("stall_seen", 32'(n_stall != 0), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected one within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
